dm_axi_master: RTL and testbench
================================

// Module: dm_axi_master
// PURPOSE
//  Data-memory access unit for the MEM stage. Turns load/store requests into AXI4-Lite-style read/write
//  transactions and produces DM_data and stall. These are the values MEM_WB captures or holds on.
//  One outstanding access at a time. stall freezes the pipeline until the access completes.
// PARAMETERS
//  ADDR_WIDTH  32  byte-address width of addr/ARADDR/AWADDR (data path fixed at 32 bits)
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   synchronous active-high reset
//  mem_read   in   1   MEM-stage load request (level, held while stalled)
//  mem_write  in   1   MEM-stage store request (level, held while stalled)
//  funct3     in   3   RV32 width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  addr       in   AW  byte address (ALU result)
//  wdata      in   32  store data, right-aligned
//  pipe_hold  in   1   other stall source is freezing the pipeline this cycle
//  stall      out  1   1 = access pending, pipeline must hold
//  DM_data    out  32  load result, sign/zero-extended, right-aligned
//  ARADDR     out  AW  read address, word-aligned
//  ARVALID    out  1   read address valid
//  ARREADY    in   1   read address accepted
//  RDATA      in   32  read data word
//  RVALID     in   1   read data valid
//  RREADY     out  1   read data ready
//  AWADDR     out  AW  write address, word-aligned
//  AWVALID    out  1   write address valid
//  AWREADY    in   1   write address accepted
//  WDATA      out  32  write data, lane-replicated
//  WSTRB      out  4   byte strobes
//  WVALID     out  1   write data valid
//  WREADY     in   1   write data accepted
//  BVALID     in   1   write response valid (response code ignored)
//  BREADY     out  1   write response ready
// BEHAVIOUR
//  Reset:
//   - rst high: state IDLE; all VALID/READY = 0; stall = 0; DM_data = 0; latched funct3/addr/wdata = 0.
//   - Reset mid-transaction abandons the access with no completion. The interconnect shares rst.
//  FSM states: IDLE, AR, R, AW_W, B, DONE.
//  IDLE:
//   - mem_read → latch funct3/addr; go to AR.
//   - mem_write (and !mem_read) → latch funct3/addr/wdata; go to AW_W.
//   - mem_read and mem_write both high → treated as a read.
//   - stall = mem_read|mem_write, combinational in this same cycle.
//  AR: ARVALID = 1. ARREADY → R.
//  R: RREADY = 1. RVALID → register extended data into DM_data; go to DONE.
//  AW_W:
//   - AWVALID and WVALID both assert on entry.
//   - Each drops independently after its own handshake; they may complete in either order or the same cycle.
//   - Both done → B.
//  B: BREADY = 1. BVALID → DONE. DM_data unchanged by stores.
//  Stall in AR/R/AW_W/B: stall = 1.
//  DONE:
//   - stall = 0; MEM_WB captures DM_data at this edge.
//   - pipe_hold = 1 → stay DONE. No reissue; DM_data stable.
//   - pipe_hold = 0 → IDLE.
//  AXI rules:
//   - VALID is held until its READY.
//   - ARADDR/AWADDR/WDATA/WSTRB are registered and stable while VALID.
//   - Addresses = {addr[AW-1:2],2'b00}.
//  Store lanes:
//   - SB: WSTRB = 4'b0001<<addr[1:0]; WDATA = {4{wdata[7:0]}}.
//   - SH: WSTRB = 4'b0011<<{addr[1],1'b0}; WDATA = {2{wdata[15:0]}}.
//   - SW: WSTRB = 4'b1111; WDATA = wdata.
//  Load extract: byte lane addr[1:0], half lane addr[1]; sign-extend for B/H, zero-extend for BU/HU.
//  Misalignment is not detected: addr[0] is ignored for H, addr[1:0] for W.
//  Min latency: load = 3 stalled cycles (IDLE, AR, R) then DONE, with zero-wait READY/VALID.
// TESTING
//  1. LW addr 0x104; ARREADY 2 cycles late; RDATA 0xDEADBEEF 3 cycles later
//     → ARADDR 0x104; stall high until DONE; DM_data 0xDEADBEEF.
//  2. RDATA 0x80FF1234 → LB 0x103 = 0xFFFFFF80; LBU 0x103 = 0x00000080;
//     LH 0x102 = 0xFFFF80FF; LHU 0x102 = 0x000080FF.
//  3. SB addr 0x201 wdata 0xAB; AWREADY 3 cycles before WREADY
//     → WSTRB 0010, WDATA 0xABABABAB; stall drops only in DONE after BVALID.
//  4. pipe_hold high 4 cycles in DONE → no new ARVALID; DM_data stable; then IDLE.
//  5. rst pulsed in R → next cycle all outputs 0, state IDLE; following LW completes normally.
//  6. LW then SW back-to-back → exactly one AR and one AW/W handshake; load data still held after the store.

Source files
------------

// File: rtl/dm_axi_master.sv
// dm_axi_master
//   Data-memory access unit for the MEM stage. A load or store request is
//   turned into one AXI4-Lite-style read or write transaction. Only one
//   access is in flight at a time, and stall holds the pipeline until the
//   access finishes. DM_data carries the sign- or zero-extended load result
//   that MEM_WB captures on the edge that leaves DONE.
//
//   Ports
//     clk, rst            clock, synchronous active-high reset
//     mem_read, mem_write level requests from the MEM stage (held while stalled)
//     funct3              RV32 width/sign code (B, H, W, BU, HU)
//     addr, wdata         byte address and right-aligned store data
//     pipe_hold           another stall source is freezing the pipeline
//     stall, DM_data      pipeline hold and load result
//     AR*/R*              read address / read data channels
//     AW*/W*/B*           write address / write data / write response channels
module dm_axi_master #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic                  pipe_hold,
    output logic                  stall,
    output logic [31:0]           DM_data,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [31:0]           RDATA,
    input  logic                  RVALID,
    output logic                  RREADY,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [31:0]           WDATA,
    output logic [3:0]            WSTRB,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic                  BVALID,
    output logic                  BREADY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW_W,
        S_B,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;      // already lane-replicated
    logic [3:0]              wstrb_q, wstrb_d;
    logic [31:0]             dm_data_q, dm_data_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;

    logic [31:0]             store_data;
    logic [3:0]              store_strb;
    logic [7:0]              load_byte;
    logic [15:0]             load_half;
    logic [31:0]             load_data;
    logic                    aw_ok;
    logic                    w_ok;

    // Store lane formatting from the live request. It is captured in IDLE so
    // that WDATA/WSTRB come straight from flops and stay stable while valid.
    always_comb begin
        store_data = wdata;
        store_strb = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                store_data = {4{wdata[7:0]}};
                store_strb = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                store_data = {2{wdata[15:0]}};
                store_strb = 4'b0011 << {addr[1], 1'b0};
            end
            default: begin
                store_data = wdata;
                store_strb = 4'b1111;
            end
        endcase
    end

    // Load extraction from the returned word. Low address bits that do not
    // select a lane are ignored (no misalignment detection).
    always_comb begin
        load_byte = RDATA[7:0];
        case (addr_q[1:0])
            2'd0:    load_byte = RDATA[7:0];
            2'd1:    load_byte = RDATA[15:8];
            2'd2:    load_byte = RDATA[23:16];
            default: load_byte = RDATA[31:24];
        endcase
        load_half = addr_q[1] ? RDATA[31:16] : RDATA[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_data = {24'h0, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b101:  load_data = {16'h0, load_half};
            default: load_data = RDATA;
        endcase
    end

    // A write channel counts as done once it has handshaken, either in an
    // earlier cycle or this one; the two channels finish independently.
    assign aw_ok = aw_done_q | AWREADY;
    assign w_ok  = w_done_q  | WREADY;

    always_comb begin
        state_d   = state_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        dm_data_d = dm_data_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            S_IDLE: begin
                // A simultaneous read and write request is served as a read.
                if (mem_read) begin
                    funct3_d = funct3;
                    addr_d   = addr;
                    state_d  = S_AR;
                end else if (mem_write) begin
                    funct3_d  = funct3;
                    addr_d    = addr;
                    wdata_d   = store_data;
                    wstrb_d   = store_strb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_AW_W;
                end
            end
            S_AR: begin
                if (ARREADY) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (RVALID) begin
                    dm_data_d = load_data;
                    state_d   = S_DONE;
                end
            end
            S_AW_W: begin
                if (aw_ok && w_ok) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_B;
                end else begin
                    aw_done_d = aw_ok;
                    w_done_d  = w_ok;
                end
            end
            S_B: begin
                if (BVALID) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Holding here while the pipeline is frozen keeps the same
                // request from being issued a second time.
                if (!pipe_hold) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            funct3_q  <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            dm_data_q <= 32'h0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            funct3_q  <= funct3_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            dm_data_q <= dm_data_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Handshake outputs are masked during reset so nothing can complete on a
    // reset edge; the interconnect is reset on the same signal.
    always_comb begin
        ARVALID = !rst && (state_q == S_AR);
        RREADY  = !rst && (state_q == S_R);
        AWVALID = !rst && (state_q == S_AW_W) && !aw_done_q;
        WVALID  = !rst && (state_q == S_AW_W) && !w_done_q;
        BREADY  = !rst && (state_q == S_B);
        // The request stalls the pipeline in the same cycle it appears.
        stall   = !rst && (((state_q == S_IDLE) && (mem_read || mem_write)) ||
                           (state_q == S_AR) || (state_q == S_R) ||
                           (state_q == S_AW_W) || (state_q == S_B));
    end

    assign ARADDR  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign AWADDR  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign DM_data = dm_data_q;

endmodule

// File: tb/tb_dm_axi_master.sv
// tb_dm_axi_master
//   Directed bench for dm_axi_master. A small AXI slave model answers with
//   configurable per-channel delays; each scenario task drives requests and
//   checks stall length, captured bus values and DM_data inline.
module tb_dm_axi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        pipe_hold = 1'b0;
    logic        stall;
    logic [31:0] DM_data;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY = 1'b0;
    logic [31:0] RDATA = 32'h0;
    logic        RVALID = 1'b0;
    logic        RREADY;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY = 1'b0;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY = 1'b0;
    logic        BVALID = 1'b0;
    logic        BREADY;

    int vectors = 0;
    int miscompares = 0;

    dm_axi_master #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .addr(addr), .wdata(wdata), .pipe_hold(pipe_hold),
        .stall(stall), .DM_data(DM_data),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BVALID(BVALID), .BREADY(BREADY)
    );

    always #5 clk = ~clk;

    // ---------------- slave model ----------------
    int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [31:0] rdata_val = 32'h0;
    int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic        r_pend = 1'b0, b_pend = 1'b0, aw_got = 1'b0, w_got = 1'b0;
    int          ar_hs = 0, aw_hs = 0, w_hs = 0, awv_cycles = 0;
    logic [31:0] araddr_seen = 32'h0, awaddr_seen = 32'h0, wdata_seen = 32'h0;
    logic [3:0]  wstrb_seen = 4'h0;
    wire         aw_g = aw_got | (AWVALID & AWREADY);
    wire         w_g  = w_got  | (WVALID & WREADY);

    always @(negedge clk) begin
        if (rst) begin
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            ARREADY = 1'b0; RVALID = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
            BVALID = 1'b0; RDATA = 32'h0;
        end else begin
            ARREADY = ARVALID && (ar_cnt == ar_delay);
            ar_cnt  = ARVALID ? ar_cnt + 1 : 0;
            AWREADY = AWVALID && (aw_cnt == aw_delay);
            aw_cnt  = AWVALID ? aw_cnt + 1 : 0;
            WREADY  = WVALID && (w_cnt == w_delay);
            w_cnt   = WVALID ? w_cnt + 1 : 0;
            if (r_pend) begin RVALID = (r_cnt >= r_delay); r_cnt = r_cnt + 1; end
            else begin RVALID = 1'b0; r_cnt = 0; end
            RDATA = RVALID ? rdata_val : 32'h0;
            if (b_pend) begin BVALID = (b_cnt >= b_delay); b_cnt = b_cnt + 1; end
            else begin BVALID = 1'b0; b_cnt = 0; end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            r_pend <= 1'b0; b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
        end else begin
            if (ARVALID && ARREADY) begin
                r_pend <= 1'b1; ar_hs <= ar_hs + 1; araddr_seen <= ARADDR;
            end
            if (RVALID && RREADY) r_pend <= 1'b0;
            if (AWVALID && AWREADY) begin aw_hs <= aw_hs + 1; awaddr_seen <= AWADDR; end
            if (WVALID && WREADY) begin
                w_hs <= w_hs + 1; wdata_seen <= WDATA; wstrb_seen <= WSTRB;
            end
            if (AWVALID) awv_cycles <= awv_cycles + 1;
            if (aw_g && w_g) begin b_pend <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0; end
            else begin aw_got <= aw_g; w_got <= w_g; end
            if (BVALID && BREADY) b_pend <= 1'b0;
        end
    end

    // Issue a request at a falling edge; return #1 after the falling edge of
    // DONE with the request still driven. n = number of stalled cycles seen.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, output int n);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        n = 0;
        #1;
        while (stall && n < 100) begin
            n++;
            @(negedge clk); #1;
        end
        $display("access rd=%0d wr=%0d f3=%03b addr=%08h wdata=%08h stalled=%0d DM_data=%08h",
                 rd, wr, f3, a, wd, n, DM_data);
    endtask

    task automatic release_req();
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if ({stall, ARVALID, RREADY, AWVALID, WVALID, BREADY} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: got %06b expected 000000",
                     {stall, ARVALID, RREADY, AWVALID, WVALID, BREADY});
        end
        vectors++;
        if (DM_data !== 32'h0) begin
            miscompares++; $display("FAIL reset_dm_data: got %08h expected 00000000", DM_data);
        end
        vectors++;
        if (ARADDR !== 32'h0 || AWADDR !== 32'h0) begin
            miscompares++; $display("FAIL reset_addr: got %08h/%08h expected 0/0", ARADDR, AWADDR);
        end
        vectors++;
        if (WDATA !== 32'h0 || WSTRB !== 4'h0) begin
            miscompares++; $display("FAIL reset_wbus: got %08h/%04b expected 0/0000", WDATA, WSTRB);
        end
        rst = 1'b0;
        @(negedge clk); #1;
        vectors++;
        if (stall !== 1'b0 || ARVALID !== 1'b0) begin
            miscompares++; $display("FAIL idle_quiet: got stall=%b ARVALID=%b expected 0 0", stall, ARVALID);
        end
        $display("reset done");
    endtask

    task automatic test_lw_delayed();
        int n; int hs0;
        hs0 = ar_hs;
        ar_delay = 2; r_delay = 3; rdata_val = 32'hDEADBEEF;
        @(negedge clk);
        access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, n);
        vectors++;
        if (n !== 8) begin miscompares++; $display("FAIL lw_stall_cycles: got %0d expected 8", n); end
        vectors++;
        if (DM_data !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL lw_data: got %08h expected deadbeef", DM_data);
        end
        vectors++;
        if (araddr_seen !== 32'h104) begin
            miscompares++; $display("FAIL lw_araddr: got %08h expected 00000104", araddr_seen);
        end
        vectors++;
        if (ar_hs - hs0 !== 1) begin
            miscompares++; $display("FAIL lw_ar_count: got %0d expected 1", ar_hs - hs0);
        end
        release_req();
        ar_delay = 0; r_delay = 0;
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
        logic [31:0] as  [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101};
        logic [31:0] exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                                 32'h000080FF, 32'h00000012};
        int n;
        rdata_val = 32'h80FF1234;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            access(1'b1, 1'b0, f3s[i], as[i], 32'h0, n);
            vectors++;
            if (DM_data !== exp[i]) begin
                miscompares++;
                $display("FAIL load_ext_%0d: got %08h expected %08h", i, DM_data, exp[i]);
            end
            vectors++;
            if (n !== 3) begin
                miscompares++; $display("FAIL load_latency_%0d: got %0d expected 3", i, n);
            end
            release_req();
        end
    endtask

    task automatic test_store_lanes();
        int n; int awv0; int aw0; int w0;
        awv0 = awv_cycles; aw0 = aw_hs; w0 = w_hs;
        aw_delay = 0; w_delay = 3; b_delay = 2;
        @(negedge clk);
        access(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000AB, n);
        vectors++;
        if (n !== 8) begin miscompares++; $display("FAIL sb_stall_cycles: got %0d expected 8", n); end
        vectors++;
        if (wstrb_seen !== 4'b0010) begin
            miscompares++; $display("FAIL sb_wstrb: got %04b expected 0010", wstrb_seen);
        end
        vectors++;
        if (wdata_seen !== 32'hABABABAB) begin
            miscompares++; $display("FAIL sb_wdata: got %08h expected abababab", wdata_seen);
        end
        vectors++;
        if (awaddr_seen !== 32'h200) begin
            miscompares++; $display("FAIL sb_awaddr: got %08h expected 00000200", awaddr_seen);
        end
        vectors++;
        if (awv_cycles - awv0 !== 1 || aw_hs - aw0 !== 1 || w_hs - w0 !== 1) begin
            miscompares++;
            $display("FAIL sb_handshakes: got awv=%0d aw=%0d w=%0d expected 1 1 1",
                     awv_cycles - awv0, aw_hs - aw0, w_hs - w0);
        end
        vectors++;
        if (DM_data !== 32'h00000012) begin
            miscompares++; $display("FAIL sb_dm_kept: got %08h expected 00000012", DM_data);
        end
        release_req();
        w_delay = 0; b_delay = 0;
        @(negedge clk);
        access(1'b0, 1'b1, 3'b001, 32'h206, 32'h1234ABCD, n);
        vectors++;
        if (wstrb_seen !== 4'b1100 || wdata_seen !== 32'hABCDABCD) begin
            miscompares++;
            $display("FAIL sh_lanes: got %04b/%08h expected 1100/abcdabcd", wstrb_seen, wdata_seen);
        end
        vectors++;
        if (n !== 3 || awaddr_seen !== 32'h204) begin
            miscompares++;
            $display("FAIL sh_timing_addr: got %0d/%08h expected 3/00000204", n, awaddr_seen);
        end
        release_req();
    endtask

    task automatic test_pipe_hold();
        int n; int hs0;
        rdata_val = 32'h0BADF00D;
        @(negedge clk);
        access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, n);
        hs0 = ar_hs;
        pipe_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            vectors++;
            if (stall !== 1'b0 || ARVALID !== 1'b0 || DM_data !== 32'h0BADF00D) begin
                miscompares++;
                $display("FAIL hold_%0d: got stall=%b ARVALID=%b DM_data=%08h expected 0 0 0badf00d",
                         i, stall, ARVALID, DM_data);
            end
        end
        pipe_hold = 1'b0;
        release_req();
        @(negedge clk); #1;
        vectors++;
        if (stall !== 1'b0 || ARVALID !== 1'b0 || ar_hs !== hs0) begin
            miscompares++;
            $display("FAIL hold_release: got stall=%b ARVALID=%b extra_ar=%0d expected 0 0 0",
                     stall, ARVALID, ar_hs - hs0);
        end
    endtask

    task automatic test_reset_mid_read();
        int n; int k;
        r_delay = 5; rdata_val = 32'h55555555;
        @(negedge clk);
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h80;
        k = 0;
        do begin @(negedge clk); #1; k++; end while (!RREADY && k < 20);
        vectors++;
        if (RREADY !== 1'b1) begin
            miscompares++; $display("FAIL reach_r: got RREADY=%b expected 1", RREADY);
        end
        rst = 1'b1; release_req();
        @(posedge clk); #1;
        vectors++;
        if ({stall, ARVALID, RREADY, AWVALID, WVALID, BREADY} !== 6'b0) begin
            miscompares++;
            $display("FAIL rst_mid_ctl: got %06b expected 000000",
                     {stall, ARVALID, RREADY, AWVALID, WVALID, BREADY});
        end
        vectors++;
        if (DM_data !== 32'h0) begin
            miscompares++; $display("FAIL rst_mid_dm: got %08h expected 00000000", DM_data);
        end
        @(negedge clk); #1;
        rst = 1'b0;
        r_delay = 0; rdata_val = 32'h12345678;
        @(negedge clk);
        access(1'b1, 1'b0, 3'b010, 32'h88, 32'h0, n);
        vectors++;
        if (n !== 3 || DM_data !== 32'h12345678 || araddr_seen !== 32'h88) begin
            miscompares++;
            $display("FAIL post_rst_lw: got %0d/%08h/%08h expected 3/12345678/00000088",
                     n, DM_data, araddr_seen);
        end
        release_req();
    endtask

    task automatic test_back_to_back();
        int n1; int n2; int ar0; int aw0; int w0;
        ar0 = ar_hs; aw0 = aw_hs; w0 = w_hs;
        rdata_val = 32'hCAFEF00D;
        @(negedge clk);
        access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, n1);
        vectors++;
        if (DM_data !== 32'hCAFEF00D || n1 !== 3) begin
            miscompares++; $display("FAIL b2b_lw: got %08h/%0d expected cafef00d/3", DM_data, n1);
        end
        // Next instruction is a store, presented the cycle right after DONE.
        mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b010; addr = 32'h304; wdata = 32'h11223344;
        @(negedge clk);
        access(1'b0, 1'b1, 3'b010, 32'h304, 32'h11223344, n2);
        vectors++;
        if (n2 !== 3) begin miscompares++; $display("FAIL b2b_sw_stall: got %0d expected 3", n2); end
        vectors++;
        if (ar_hs - ar0 !== 1 || aw_hs - aw0 !== 1 || w_hs - w0 !== 1) begin
            miscompares++;
            $display("FAIL b2b_counts: got ar=%0d aw=%0d w=%0d expected 1 1 1",
                     ar_hs - ar0, aw_hs - aw0, w_hs - w0);
        end
        vectors++;
        if (wstrb_seen !== 4'b1111 || wdata_seen !== 32'h11223344 || awaddr_seen !== 32'h304) begin
            miscompares++;
            $display("FAIL b2b_sw_bus: got %04b/%08h/%08h expected 1111/11223344/00000304",
                     wstrb_seen, wdata_seen, awaddr_seen);
        end
        vectors++;
        if (DM_data !== 32'hCAFEF00D) begin
            miscompares++; $display("FAIL b2b_dm_held: got %08h expected cafef00d", DM_data);
        end
        release_req();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_lw_delayed();
        test_load_extend();
        test_store_lanes();
        test_pipe_hold();
        test_reset_mid_read();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
